serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Adds A + B + Cin one bit per clock through a single 1-bit full-adder cell,
// then presents a registered result with carry-out and two's-complement
// overflow.
//
// Ports:
//   clk   - rising-edge clock for all state
//   rst   - synchronous, active-high reset
//   start - begin an addition (sampled only when idle)
//   a, b  - WIDTH-bit operands, captured when start is accepted
//   cin   - carry-in, captured when start is accepted
//   busy  - high while an addition is running or completing
//   done  - one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum   - registered result, a + b + cin mod 2^WIDTH
//   cout  - registered carry out of the MSB
//   ovf   - registered signed overflow (carry into MSB xor carry out)

// 1-bit full-adder cell, port order (cout, sum, a, b, cin).
module fa_cell (
    output logic cout,
    output logic sum,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic fa_sum;
    logic fa_cout;

    fa_cell u_fa (
        .cout (fa_cout),
        .sum  (fa_sum),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_sh_q <= {fa_sum, res_sh_q[WIDTH-1:1]};
                    carry_q  <= fa_cout;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    if (cnt_q == LastCnt) begin
                        // Last bit: the outputs take the shift register's
                        // next value, and carry_q is still the carry into
                        // the MSB, so overflow is formed at this edge. The
                        // counter holds rather than wrapping.
                        sum     <= {fa_sum, res_sh_q[WIDTH-1:1]};
                        cout    <= fa_cout;
                        ovf     <= fa_cout ^ carry_q;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance, checked every cycle against the model.
    logic       rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    // WIDTH=4 instance, for the exhaustive sweep.
    logic       rst4, start4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: a countdown of the cycles left in the current
    // operation plus the arithmetic result computed at acceptance.
    int         m_rem = 0;
    logic       m_ok = 1'b0;
    logic [7:0] m_sum = '0, m_rsum = '0;
    logic       m_cout = 1'b0, m_rcout = 1'b0;
    logic       m_ovf = 1'b0, m_rovf = 1'b0;

    always @(posedge clk) begin
        logic [8:0] full;
        if (rst) begin
            m_rem  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_ok   <= 1'b1;
        end else if (m_rem == 0) begin
            if (start) begin
                full    = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                m_rem   <= 8 + 1;
                m_rsum  <= full[7:0];
                m_rcout <= full[8];
                m_rovf  <= (a[7] == b[7]) && (full[7] != a[7]);
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_sum  <= m_rsum;
                m_cout <= m_rcout;
                m_ovf  <= m_rovf;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", busy, m_rem != 0);
            chk("done", done, m_rem == 1);
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", busy, 0);
    endtask

    // One addition with scrambled inputs after capture; literal expectations.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string tag);
        int cnt = 0;
        wait_idle();
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cnt < 30) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        int cnt;
        int last;
        rst = 1'b1; start = 1'b1; a = 8'h5a; b = 8'h33; cin = 1'b1;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(negedge clk);
        // Reset wins over a simultaneous start.
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0; start = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
        run_op(8'hff, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_1");
        run_op(8'h7f, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_1");
        run_op(8'ha5, 8'h5a, 1'b1, 8'h00, 1'b1, 1'b0, "a5_5a");
        run_op(8'hff, 8'hff, 1'b1, 8'hff, 1'b1, 1'b0, "ff_ff");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "80_80");

        // Start pulsed with new operands mid-run is ignored.
        wait_idle();
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hff; b = 8'hff; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 3;
        while (!done && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk("ignore_latency", cnt, 8);
        chk("ignore_sum", sum, 8'h46);

        // Reset mid-run aborts with no done pulse.
        wait_idle();
        a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_done", done, 0);
        repeat (12) @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after_abort");

        // Start held high: one result every WIDTH+2 cycles.
        wait_idle();
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        last = -1;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (done) begin
                chk("held_sum", sum, 8'h30);
                if (last >= 0) chk("held_period", i - last, 10);
                last = i;
            end
        end
        start = 1'b0;
        chk("held_seen", last >= 0, 1);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        wait_idle();

        // Exhaustive sweep of the WIDTH=4 instance.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int s;
                    int k;
                    k = 0;
                    while (busy4 && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    k = 0;
                    while (!done4 && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    s = ia + ib + ic;
                    chk("sweep_done", done4, 1);
                    chk("sweep_sum", sum4, s & 15);
                    chk("sweep_cout", cout4, (s >> 4) & 1);
                    chk("sweep_ovf", ovf4,
                        ((ia >> 3) == (ib >> 3)) && (((s >> 3) & 1) != (ia >> 3)));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
